// File: rtl/ctrl_pkg.sv
// Shared types and limits for the iterative-datapath controller.
// Holds the state encoding and the legal multiplier latency range.
package ctrl_pkg;

  localparam int unsigned MultCycMin = 1;
  localparam int unsigned MultCycMax = 8;
  localparam int unsigned MultCntW   = $clog2(MultCycMax);

  // Encoding 3'd7 is unused and falls back to StIdle.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRead   = 3'd1,
    StLoad   = 3'd2,
    StMult   = 3'd3,
    StSum    = 3'd4,
    StUpdate = 3'd5,
    StDone   = 3'd6
  } state_e;

  function automatic int unsigned clamp_mult_cyc(input int unsigned cyc);
    if (cyc < MultCycMin) return MultCycMin;
    if (cyc > MultCycMax) return MultCycMax;
    return cyc;
  endfunction

endpackage

// File: rtl/iter_controller_if.sv
// Control/status bundle between the iteration controller and its datapath.
// master = datapath/host side, slave = controller side.
interface iter_controller_if #(
  parameter int unsigned CNT_W = 4
) ();

  logic             start;
  logic [CNT_W-1:0] n_iter;
  logic             converged;
  logic             read;
  logic             ld_y;
  logic             slc_y;
  logic             mult;
  logic             sum;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] iter_cnt;
  logic             max_hit;

  modport master (
    output start, n_iter, converged,
    input  read, ld_y, slc_y, mult, sum, done, busy, iter_cnt, max_hit
  );

  modport slave (
    input  start, n_iter, converged,
    output read, ld_y, slc_y, mult, sum, done, busy, iter_cnt, max_hit
  );

endinterface

// File: rtl/iter_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over enable.
module iter_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/iter_controller.sv
// Sequencer for an iterative multiply/accumulate datapath with early exit on
// convergence or an iteration limit; outputs are decoded from the state register.
module iter_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MULT_CYC = 1
) (
  input logic               clk,
  input logic               rst,
  iter_controller_if.slave  bus
);

  localparam int unsigned MultCyc = clamp_mult_cyc(MULT_CYC);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       n_lat_q, n_lat_d;
  logic                   max_hit_q, max_hit_d;
  logic [CNT_W-1:0]       iter_cnt;
  logic [MultCntW-1:0]    mult_cnt;
  logic [CNT_W-1:0]       limit;
  logic [CNT_W:0]         iter_next;
  logic                   accept, mult_last, limit_hit;

  assign accept    = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign mult_last = (mult_cnt == MultCntW'(MultCyc - 1));
  // A latched count of zero runs a single iteration.
  assign limit     = (n_lat_q == '0) ? CNT_W'(1) : n_lat_q;
  assign iter_next = {1'b0, iter_cnt} + (CNT_W + 1)'(1);
  assign limit_hit = (iter_next >= {1'b0, limit});

  always_comb begin
    state_d   = state_q;
    n_lat_d   = n_lat_q;
    max_hit_d = max_hit_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StRead;
          n_lat_d   = bus.n_iter;
          max_hit_d = 1'b0;
        end
      end
      StRead:  state_d = StLoad;
      StLoad:  state_d = StMult;
      StMult:  if (mult_last) state_d = StSum;
      StSum:   state_d = StUpdate;
      StUpdate: begin
        // Convergence wins over the limit so a coincident hit reports max_hit=0.
        if (bus.converged) begin
          state_d = StDone;
        end else if (limit_hit) begin
          state_d   = StDone;
          max_hit_d = 1'b1;
        end else begin
          state_d = StMult;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      n_lat_q   <= '0;
      max_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_lat_q   <= n_lat_d;
      max_hit_q <= max_hit_d;
    end
  end

  iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (accept),
    .en_i   (state_q == StUpdate),
    .cnt_o  (iter_cnt)
  );

  // Cleared outside MULT and on its last cycle so each iteration restarts at zero.
  iter_counter #(
    .CNT_W (MultCntW)
  ) u_mult_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  ((state_q != StMult) || mult_last),
    .en_i   (state_q == StMult),
    .cnt_o  (mult_cnt)
  );

  assign bus.read     = (state_q == StRead);
  assign bus.ld_y     = (state_q == StLoad) || (state_q == StUpdate);
  assign bus.slc_y    = (state_q == StUpdate);
  assign bus.mult     = (state_q == StMult);
  assign bus.sum      = (state_q == StSum);
  assign bus.done     = (state_q == StDone);
  assign bus.busy     = (state_q == StRead) || (state_q == StLoad) || (state_q == StMult) ||
                        (state_q == StSum)  || (state_q == StUpdate);
  assign bus.iter_cnt = iter_cnt;
  assign bus.max_hit  = max_hit_q;

endmodule

// File: tb/tb_iter_controller.sv
// Scoreboard bench for iter_controller: two instances (MULT_CYC=1 and 3) share
// stimulus; sel picks which one a run drives and observes.
module tb_iter_controller;

  localparam int unsigned CntW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iter_controller_if #(.CNT_W(CntW)) bus1 ();
  iter_controller_if #(.CNT_W(CntW)) bus3 ();

  iter_controller #(.CNT_W(CntW), .MULT_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  iter_controller #(.CNT_W(CntW), .MULT_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic            start_r, conv_r, sel;
  logic [CntW-1:0] n_r;

  assign bus1.start     = start_r && !sel;
  assign bus3.start     = start_r && sel;
  assign bus1.n_iter    = n_r;
  assign bus3.n_iter    = n_r;
  assign bus1.converged = conv_r;
  assign bus3.converged = conv_r;

  logic o_read, o_ldy, o_slcy, o_mult, o_sum, o_done, o_busy, o_hit;
  logic [CntW-1:0] o_iter;
  logic [6:0]      o_ctl;

  assign o_read = sel ? bus3.read     : bus1.read;
  assign o_ldy  = sel ? bus3.ld_y     : bus1.ld_y;
  assign o_slcy = sel ? bus3.slc_y    : bus1.slc_y;
  assign o_mult = sel ? bus3.mult     : bus1.mult;
  assign o_sum  = sel ? bus3.sum      : bus1.sum;
  assign o_done = sel ? bus3.done     : bus1.done;
  assign o_busy = sel ? bus3.busy     : bus1.busy;
  assign o_hit  = sel ? bus3.max_hit  : bus1.max_hit;
  assign o_iter = sel ? bus3.iter_cnt : bus1.iter_cnt;
  assign o_ctl  = {o_read, o_ldy, o_slcy, o_mult, o_sum, o_done, o_busy};

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d", tag, obs, obs, exp);
    end
  endtask

  typedef struct {
    int unsigned lat;
    int unsigned cnt;
    int unsigned hit;
  } exp_t;

  exp_t sb[$];

  // conv_at: UPDATE index (1-based) at which converged is raised, 0 = never.
  task automatic run(input bit s, input int unsigned n, input int unsigned conv_at,
                     input bit pulse);
    int unsigned mc, lim, k, e, upd, mrun;
    exp_t x, got;
    bit fin;
    mc  = s ? 3 : 1;
    lim = (n == 0) ? 1 : n;
    if (conv_at != 0 && conv_at <= lim) begin
      k = conv_at; x.hit = 0;
    end else begin
      k = lim; x.hit = 1;
    end
    x.cnt = k;
    x.lat = 2 + k * (mc + 2);

    @(negedge clk);
    sel = s; n_r = CntW'(n); start_r = 1'b1;
    sb.push_back(x);
    @(negedge clk);
    start_r = 1'b0;
    e = 0; upd = 0; mrun = 0; fin = 0;
    check_eq("start_read", o_read, 1);
    check_eq("start_done_drop", o_done, 0);
    while (!fin && e < 300) begin
      check_eq("onehot", ($countones({o_read, o_mult, o_sum, o_done}) <= 1), 1);
      if (o_mult) begin
        mrun++;
      end else if (mrun != 0) begin
        check_eq("mult_len", mrun, mc);
        mrun = 0;
      end
      conv_r = o_slcy && ((upd + 1) == conv_at);
      if (o_slcy) upd++;
      if (pulse && o_busy && (e % 3 == 1)) begin
        start_r = 1'b1;
        n_r     = CntW'($urandom);
      end else begin
        start_r = 1'b0;
      end
      if (o_done) begin
        fin = 1;
        got = sb.pop_front();
        check_eq("latency", e, got.lat);
        check_eq("iter_cnt", o_iter, got.cnt);
        check_eq("max_hit", o_hit, got.hit);
        check_eq("busy_at_done", o_busy, 0);
      end else begin
        @(posedge clk);
        @(negedge clk);
        e++;
      end
    end
    conv_r  = 1'b0;
    start_r = 1'b0;
    check_eq("timeout", fin, 1);
    if (!fin) begin
      void'(sb.pop_front());
    end else begin
      @(negedge clk);
      check_eq("done_hold", o_done, 1);
    end
  endtask

  initial begin
    int unsigned e;
    rst = 1'b0; start_r = 1'b0; conv_r = 1'b0; n_r = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctl_mc1", o_ctl, 0);
    sel = 1'b1;
    #1 check_eq("rst_ctl_mc3", o_ctl, 0);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_ctl", o_ctl, 0);
    check_eq("idle_iter", o_iter, 0);

    run(1'b0, 3, 0, 1'b0);   // three full loops, done at 11
    run(1'b0, 5, 2, 1'b0);   // early convergence
    run(1'b0, 0, 0, 1'b0);   // zero acts as one
    run(1'b0, 2, 2, 1'b0);   // convergence and limit together
    run(1'b0, 1, 0, 1'b0);   // restart from DONE
    run(1'b1, 2, 0, 1'b1);   // 3-cycle multiply, start pulses while busy
    run(1'b1, 4, 3, 1'b1);
    run(1'b0, 15, 0, 1'b1);  // maximum count

    // Abort mid-run: reset during the second MULT.
    @(negedge clk);
    sel = 1'b0; n_r = CntW'(5); start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    e = 0;
    while (!(o_mult && o_iter == 1) && e < 50) begin
      @(negedge clk);
      e++;
    end
    check_eq("reach_mult2", (o_mult && o_iter == 1), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_async_ctl", o_ctl, 0);
    check_eq("rst_async_iter", o_iter, 0);
    check_eq("rst_async_hit", o_hit, 0);
    @(posedge clk);
    #1 check_eq("rst_hold_ctl", o_ctl, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ctl", o_ctl, 0);
    check_eq("post_rst_iter", o_iter, 0);
    run(1'b0, 1, 0, 1'b0);   // fresh run after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
